// File: rtl/vending_if.sv
// Vending controller <-> datapath/coin-acceptor signal bundle.
// master = controller side, slave = datapath/environment side.
interface vending_if;
  logic coin;
  logic tot_lt_s;
  logic tot_ld;
  logic tot_clr;
  logic d;
  logic busy;

  modport master (
    input  coin,
    input  tot_lt_s,
    output tot_ld,
    output tot_clr,
    output d,
    output busy
  );

  modport slave (
    output coin,
    output tot_lt_s,
    input  tot_ld,
    input  tot_clr,
    input  d,
    input  busy
  );
endinterface

// File: rtl/vending_ctrl.sv
// Vending machine control FSM: counts coin rising edges, sequences total load and
// price compare, pulses dispense, and clears an abandoned partial total after idling.
module vending_ctrl #(
  parameter int DISP_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic      clk_i,
  input logic      rst_i,
  vending_if.master bus
);

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DISP  = 3'd4;

  localparam int IW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int DW = (DISP_CYCLES < 2) ? 1 : $clog2(DISP_CYCLES);
  localparam logic [IW-1:0] IDLE_LAST = (TIMEOUT_CYCLES == 0) ? '0 : IW'(TIMEOUT_CYCLES - 1);
  localparam logic [DW-1:0] DISP_LAST = DW'(DISP_CYCLES - 1);

  logic [2:0]    r_state;
  logic          r_coin_q;
  logic          r_pend;
  logic [DW-1:0] r_disp_cnt;
  logic [IW-1:0] r_idle_cnt;

  logic [2:0]    w_state_next;
  logic          w_pend_next;
  logic [DW-1:0] w_disp_cnt_next;
  logic [IW-1:0] w_idle_cnt_next;
  logic          w_coin_rise;

  assign w_coin_rise = bus.coin & ~r_coin_q;

  always_comb begin
    w_state_next    = r_state;
    w_pend_next     = r_pend;
    w_disp_cnt_next = r_disp_cnt;
    w_idle_cnt_next = '0;
    case (r_state)
      S_INIT: begin
        w_state_next = S_WAIT;
        w_pend_next  = 1'b0;
      end
      S_WAIT: begin
        if (w_coin_rise || r_pend) begin
          w_state_next = S_ADD;
          w_pend_next  = 1'b0;
        end else begin
          // Saturate rather than wrap so a disabled timeout never aliases to zero.
          w_idle_cnt_next = (r_idle_cnt != {IW{1'b1}}) ? r_idle_cnt + IW'(1) : r_idle_cnt;
          if ((TIMEOUT_CYCLES != 0) && (r_idle_cnt == IDLE_LAST)) begin
            w_state_next    = S_INIT;
            w_idle_cnt_next = '0;
          end
        end
      end
      S_ADD: begin
        w_state_next = S_CHECK;
        if (w_coin_rise) w_pend_next = 1'b1;
      end
      S_CHECK: begin
        if (w_coin_rise) w_pend_next = 1'b1;
        if (!bus.tot_lt_s) begin
          w_state_next    = S_DISP;
          w_disp_cnt_next = '0;
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_DISP: begin
        w_disp_cnt_next = r_disp_cnt + DW'(1);
        if (r_disp_cnt == DISP_LAST) begin
          w_state_next = S_INIT;
          w_pend_next  = 1'b0;
        end
      end
      default: begin
        w_state_next = S_INIT;
        w_pend_next  = 1'b0;
      end
    endcase
  end

  // coin_q resets high so a coin already present at reset is not counted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_INIT;
      r_coin_q   <= 1'b1;
      r_pend     <= 1'b0;
      r_disp_cnt <= '0;
      r_idle_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_coin_q   <= bus.coin;
      r_pend     <= w_pend_next;
      r_disp_cnt <= w_disp_cnt_next;
      r_idle_cnt <= w_idle_cnt_next;
    end
  end

  assign bus.tot_clr = (r_state == S_INIT);
  assign bus.tot_ld  = (r_state == S_ADD);
  assign bus.d       = (r_state == S_DISP);
  assign bus.busy    = (r_state != S_WAIT);

endmodule
